// File: rtl/mld_15_7_encoder.sv
// Serial systematic (15,7) cyclic-code encoder, g(x)=1+x^4+x^6+x^7+x^8.
// Ports: clk, reset (async low), msg_valid/msg_ready/msg_data[6:0] in;
//   code_bit, code_valid, frame_start, frame_end, busy out.
//   ERROR_INJECT_EN adds err_en, err_pos[3:0] (per-frame bit flip).
module mld_15_7_encoder #(
  parameter int unsigned GAP_CYCLES = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       msg_valid,
  output logic       msg_ready,
  input  logic [6:0] msg_data,
`ifdef ERROR_INJECT_EN
  input  logic       err_en,
  input  logic [3:0] err_pos,
`endif
  output logic       code_bit,
  output logic       code_valid,
  output logic       frame_start,
  output logic       frame_end,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE,
    MSG,
    PAR,
    GAP
  } state_e;

  // Zero gap lets a new message be taken while p0 is on the wire.
  localparam bit B2B = (GAP_CYCLES == 0);
  // The IDLE accept cycle is itself one of the forced idle cycles,
  // so GAP proper lasts GAP_CYCLES-1 cycles.
  localparam bit USE_GAP = (GAP_CYCLES > 1);
  localparam logic [3:0] GAP_LAST =
    USE_GAP ? 4'(GAP_CYCLES - 2) : 4'd0;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] gap_q, gap_d;
  logic [6:0] msg_q, msg_d;
  logic [7:0] lfsr_q, lfsr_d;
  logic       bit_d;
  logic       code_d;
  logic       valid_d;
  logic       fs_d;
  logic       fe_d;
  logic       accept;

  function automatic logic [7:0] lfsr_step(
    input logic [7:0] r,
    input logic       m
  );
    logic fb;
    fb = m ^ r[7];
    lfsr_step = {r[6] ^ fb, r[5] ^ fb, r[4], r[3] ^ fb,
                 r[2], r[1], r[0], fb};
  endfunction

  assign msg_ready = (state_q == IDLE) ||
                     (B2B && state_q == PAR && cnt_q == 4'd14);
  assign accept    = msg_valid & msg_ready;
  assign busy      = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    msg_d   = msg_q;
    lfsr_d  = lfsr_q;
    bit_d   = 1'b0;
    valid_d = 1'b0;
    fs_d    = 1'b0;
    fe_d    = 1'b0;
    if (accept) begin
      // u6 goes out on the accept edge; LFSR restarts from zero.
      state_d = MSG;
      cnt_d   = 4'd0;
      gap_d   = 4'd0;
      bit_d   = msg_data[6];
      valid_d = 1'b1;
      fs_d    = 1'b1;
      lfsr_d  = lfsr_step(8'h00, msg_data[6]);
      msg_d   = {msg_data[5:0], 1'b0};
    end else begin
      unique case (state_q)
        IDLE: ;
        MSG: begin
          cnt_d   = cnt_q + 4'd1;
          valid_d = 1'b1;
          if (cnt_q == 4'd6) begin
            state_d = PAR;
            bit_d   = lfsr_q[7];
            lfsr_d  = {lfsr_q[6:0], 1'b0};
          end else begin
            bit_d   = msg_q[6];
            lfsr_d  = lfsr_step(lfsr_q, msg_q[6]);
            msg_d   = {msg_q[5:0], 1'b0};
          end
        end
        PAR: begin
          if (cnt_q == 4'd14) begin
            cnt_d   = 4'd0;
            gap_d   = 4'd0;
            state_d = USE_GAP ? GAP : IDLE;
          end else begin
            cnt_d   = cnt_q + 4'd1;
            valid_d = 1'b1;
            fe_d    = (cnt_q == 4'd13);
            bit_d   = lfsr_q[7];
            lfsr_d  = {lfsr_q[6:0], 1'b0};
          end
        end
        GAP: begin
          if (gap_q == GAP_LAST) begin
            state_d = IDLE;
          end else begin
            gap_d = gap_q + 4'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

`ifdef ERROR_INJECT_EN
  logic       err_en_q;
  logic [3:0] err_pos_q;
  logic       flip_en;
  logic [3:0] flip_pos;
  logic [3:0] pos_d;

  // Position index counts down: c14 is sent at bit count 0.
  always_comb begin
    pos_d    = 4'd14 - cnt_d;
    flip_en  = accept ? err_en  : err_en_q;
    flip_pos = accept ? err_pos : err_pos_q;
    code_d   = bit_d ^ (valid_d & flip_en & (flip_pos == pos_d));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_en_q  <= 1'b0;
      err_pos_q <= 4'd15;
    end else if (accept) begin
      err_en_q  <= err_en;
      err_pos_q <= err_pos;
    end
  end
`else
  assign code_d = bit_d;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      gap_q       <= 4'd0;
      msg_q       <= 7'd0;
      lfsr_q      <= 8'd0;
      code_bit    <= 1'b0;
      code_valid  <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      gap_q       <= gap_d;
      msg_q       <= msg_d;
      lfsr_q      <= lfsr_d;
      code_bit    <= code_d;
      code_valid  <= valid_d;
      frame_start <= fs_d;
      frame_end   <= fe_d;
    end
  end

endmodule
